// File: rtl/reg_dump_reader.sv
// Debug read master: walks a register index range through the shared RF read port
// and streams {index, value} beats out. Define REG_DUMP_CHECKSUM_EN for a trailing XOR beat.
module reg_dump_reader #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IW-1:0]   start_idx,
  input  logic [IW-1:0]   end_idx,
  output logic            rf_req,
  input  logic            rf_gnt,
  output logic [IW-1:0]   rf_addr,
  input  logic [XLEN-1:0] rf_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   out_idx,
  output logic [XLEN-1:0] out_data,
  output logic            out_last,
  output logic            out_csum,
  output logic            busy,
  output logic            done
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_CSUM} state_t;
  logic [XLEN-1:0] csum_q, csum_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND} state_t;
`endif

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   end_q, end_d;
  logic [IW-1:0]   oidx_q, oidx_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            last_q, last_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    end_d   = end_q;
    oidx_d  = oidx_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        idx_d   = start_idx;
        end_d   = end_idx;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d  = '0;
`endif
        state_d = S_READ;
      end
      S_READ: if (rf_gnt) begin
        data_d  = rf_data;
        oidx_d  = idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
        last_d  = 1'b0;
        csum_d  = csum_q ^ rf_data;
`else
        last_d  = (idx_q == end_q);
`endif
        state_d = S_SEND;
      end
      S_SEND: if (out_ready) begin
        if (idx_q == end_q) begin
`ifdef REG_DUMP_CHECKSUM_EN
          data_d  = csum_q;
          oidx_d  = '0;
          last_d  = 1'b1;
          state_d = S_CSUM;
`else
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          // index width equals log2(NREGS), so the increment wraps 31 -> 0
          idx_d   = idx_q + IW'(1);
          state_d = S_READ;
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM: if (out_ready) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      end_q   <= '0;
      oidx_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      end_q   <= end_d;
      oidx_q  <= oidx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign rf_req    = (state_q == S_READ);
  assign rf_addr   = idx_q;
  assign out_idx   = oidx_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
`ifdef REG_DUMP_CHECKSUM_EN
  assign out_valid = (state_q == S_SEND) || (state_q == S_CSUM);
  assign out_csum  = (state_q == S_CSUM);
`else
  assign out_valid = (state_q == S_SEND);
  assign out_csum  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader against a behavioural register file.
module tb_reg_dump_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  start_idx = '0, end_idx = '0;
  logic        rf_req, rf_gnt = 1'b1;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid, out_ready = 1'b1;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last, out_csum, busy, done;

  logic [31:0] regs [32];
  int n_cmp = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rf_data = regs[rf_addr];

  reg_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_idx(start_idx), .end_idx(end_idx),
    .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
    .out_last(out_last), .out_csum(out_csum), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
  endtask

  // stall_beat / abort_at are beat ordinals (-1 = none); gnt_hold = cycles of withheld grant
  task automatic dump(input int s, input int e, input int stall_beat, input int gnt_hold,
                      input int abort_at);
    int n = ((e - s) & 31) + 1;
    int t0, idx;
    logic [31:0] x = '0;
    rf_gnt = (gnt_hold == 0);
    @(posedge clk); #1;
    start = 1'b1; start_idx = 5'(s); end_idx = 5'(e); t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int h = 0; h < gnt_hold; h++) begin
      @(negedge clk);
      chk("gnt_req", rf_req, 1);
      chk("gnt_addr", rf_addr, 32'(s));
      chk("gnt_novalid", out_valid, 0);
    end
    rf_gnt = 1'b1;
    for (int k = 0; k < n; k++) begin
      idx = (s + k) & 31;
      wait_valid("beat_valid");
      if (k == 0 && gnt_hold == 0) chk("first_lat", 32'(cyc - t0), 2);
      chk("beat_idx", out_idx, 32'(idx));
      chk("beat_data", out_data, regs[idx]);
`ifdef REG_DUMP_CHECKSUM_EN
      chk("beat_last", out_last, 0);
`else
      chk("beat_last", out_last, (k == n - 1) ? 1 : 0);
`endif
      chk("beat_csum", out_csum, 0);
      chk("no_req_in_send", rf_req, 0);
      x ^= regs[idx];
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_req", rf_req, 0);
        @(negedge clk);
        chk("rst_done2", done, 0);
        return;
      end
      if (k == stall_beat) begin
        out_ready = 1'b0;
        start = 1'b1; start_idx = 5'd20; end_idx = 5'd20;
        for (int w = 0; w < 4; w++) begin
          @(negedge clk);
          start = 1'b0;
          chk("stall_valid", out_valid, 1);
          chk("stall_idx", out_idx, 32'(idx));
          chk("stall_data", out_data, regs[idx]);
        end
        out_ready = 1'b1;
      end
      if (k == n - 1 && gnt_hold == 0 && stall_beat < 0) chk("last_hs_cyc", 32'(cyc - t0), 32'(2 * n));
      @(posedge clk);
    end
`ifdef REG_DUMP_CHECKSUM_EN
    wait_valid("csum_valid");
    chk("csum_flag", out_csum, 1);
    chk("csum_last", out_last, 1);
    chk("csum_idx", out_idx, 0);
    chk("csum_data", out_data, x);
    @(posedge clk);
`endif
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    @(negedge clk);
    chk("done_once", done, 0);
  endtask

  initial begin
    regs[0] = '0;
    for (int i = 1; i < 32; i++) regs[i] = 32'(i * 16 + 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy0", busy, 0);
    chk("rst_req0", rf_req, 0);
    chk("rst_addr0", rf_addr, 0);
    chk("rst_valid0", out_valid, 0);
    chk("rst_idx0", out_idx, 0);
    chk("rst_data0", out_data, 0);
    chk("rst_last0", out_last, 0);
    chk("rst_csum0", out_csum, 0);
    chk("rst_done0", done, 0);
    rst = 1'b0;

    dump(0, 31, -1, 0, -1);   // full dump, timing
    dump(3, 5, 1, 0, -1);     // back-pressure on idx 4, start while busy ignored
    dump(30, 1, -1, 0, -1);   // wrap 30,31,0,1
    dump(7, 9, -1, 5, -1);    // grant withheld 5 cycles
    dump(0, 31, -1, 0, 10);   // reset during beat 10
    dump(0, 0, -1, 0, -1);    // single beat x0
    regs[1] = 32'hA; regs[2] = 32'h5; regs[3] = 32'hF0;
    dump(1, 3, -1, 0, -1);    // checksum 0xFF when enabled

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
